// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default bus widths and the RAM arbiter state encoding.
package sap1_pkg;

    localparam int SAP1_ADDR_W = 4;
    localparam int SAP1_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_CPU,
        ST_DRAIN,
        ST_HOST_IDLE,
        ST_HOST_ACC,
        ST_HOST_DONE,
        ST_HANDBACK
    } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Host idle watchdog: counts consecutive idle granted cycles and blocks re-grant until host_own drops.
module mem_arb_watchdog
    import sap1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  arb_state_t state,
    input  logic       host_own,
    input  logic       host_valid,
    output logic       expire,
    output logic       rearm_block,
    output logic       host_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_tick;

    // A release request takes priority over the watchdog, so only count while ownership is still held.
    assign idle_tick = (state == ST_HOST_IDLE) && host_own && !host_valid;
    assign expire    = idle_tick && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt     <= '0;
            rearm_block  <= 1'b0;
            host_timeout <= 1'b0;
        end else begin
            host_timeout <= expire;
            if (!idle_tick || expire) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end
            if (!host_own) begin
                rearm_block <= 1'b0;
            end else if (expire) begin
                rearm_block <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// SAP-1 RAM arbiter between the CPU datapath and a host loader port.
// Optional host idle watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import sap1_pkg::*;
#(
    parameter int ADDR_W         = SAP1_ADDR_W,
    parameter int DATA_W         = SAP1_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_idle,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_own,
    output logic              host_grant,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_timeout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    logic              accept;
    logic              expire;
    logic              rearm_block;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .host_own    (host_own),
        .host_valid  (host_valid),
        .expire      (expire),
        .rearm_block (rearm_block),
        .host_timeout(host_timeout)
    );
`else
    assign expire       = 1'b0;
    assign rearm_block  = 1'b0;
    assign host_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_CPU: begin
                if (host_own && !rearm_block) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!host_own)     state_nxt = ST_CPU;
                else if (cpu_idle) state_nxt = ST_HOST_IDLE;
            end
            ST_HOST_IDLE: begin
                if (!host_own) begin
                    state_nxt = ST_HANDBACK;
                end else if (host_valid) begin
                    state_nxt = ST_HOST_ACC;
                    accept    = 1'b1;
                end else if (expire) begin
                    state_nxt = ST_HANDBACK;
                end
            end
            ST_HOST_ACC:  state_nxt = ST_HOST_DONE;
            ST_HOST_DONE: state_nxt = ST_HOST_IDLE;
            ST_HANDBACK:  state_nxt = ST_CPU;
            default:      state_nxt = ST_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            host_rdata <= '0;
        end else begin
            if (accept) begin
                lat_addr  <= host_addr;
                lat_we    <= host_we;
                lat_wdata <= host_wdata;
            end
            if (state == ST_HOST_ACC && !lat_we) begin
                host_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_stall  = (state != ST_CPU);
    assign host_grant = (state == ST_HOST_IDLE) || (state == ST_HOST_ACC) || (state == ST_HOST_DONE);
    assign host_done  = (state == ST_HOST_DONE);
    assign mem_addr   = (state == ST_HOST_ACC) ? lat_addr : cpu_addr;
    assign mem_wdata  = lat_wdata;
    // Gated by rst so an access interrupted by reset never reaches the RAM.
    assign mem_we     = (state == ST_HOST_ACC) && lat_we && !rst;
    assign cpu_rdata  = mem_rdata;

endmodule
